// File: rtl/hpm_counter_ctrl.sv
// Performance-monitor counter bank: NUM_COUNTERS 64-bit counters with pipelined increment and a 32-bit CSR port.
// Optional macro HPM_OVF_EN enables sticky per-counter overflow flags mirrored in mhpmevent bit 31.
module hpm_counter_ctrl #(
    parameter int NUM_COUNTERS = 2,
    parameter int NUM_EVENTS   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    csr_active,
    input  logic                    csr_write,
    input  logic [11:0]             csr_addr,
    input  logic [31:0]             csr_wdata,
    output logic [31:0]             csr_rdata,
    output logic                    csr_ack,
    output logic                    csr_invalid,
    input  logic [NUM_EVENTS-1:0]   events,
    output logic [NUM_COUNTERS-1:0] overflow
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RESP = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]              state;
    logic [31:0]             cnt_lo [NUM_COUNTERS];
    logic [31:0]             cnt_hi [NUM_COUNTERS];
    logic [7:0]              evsel  [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] inhibit;
    logic [NUM_COUNTERS-1:0] inc_q;
    logic [NUM_COUNTERS-1:0] carry_q;
    logic [NUM_COUNTERS-1:0] ovf;
    logic [31:0]             rdata_q;
    logic                    inv_q;

    logic [31:0]             rd_val;
    logic                    rd_hit;
    logic                    wr_ok;
    logic                    accept;
    logic                    bad;
    logic                    commit;
    logic                    we_inh;
    logic [NUM_COUNTERS-1:0] we_lo;
    logic [NUM_COUNTERS-1:0] we_hi;
    logic [NUM_COUNTERS-1:0] we_ev;
    logic [NUM_COUNTERS-1:0] sel_ev;
    logic [NUM_COUNTERS-1:0] lo_carry;
    logic [31:0]             lo_next [NUM_COUNTERS];
    logic [31:0]             hi_next [NUM_COUNTERS];
`ifdef HPM_OVF_EN
    logic [NUM_COUNTERS-1:0] hi_wrap;
`endif

    // Event codes 0 and anything above NUM_EVENTS match no strobe.
    function automatic logic pick_event(input logic [7:0] code, input logic [NUM_EVENTS-1:0] ev);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_EVENTS; k++) begin
            if (code == 8'(k + 1)) hit = ev[k];
        end
        return hit;
    endfunction

    always_comb begin
        rd_val = '0;
        rd_hit = 1'b0;
        wr_ok  = 1'b0;
        we_inh = 1'b0;
        we_lo  = '0;
        we_hi  = '0;
        we_ev  = '0;
        if (csr_addr == 12'h320) begin
            rd_hit = 1'b1;
            wr_ok  = 1'b1;
            we_inh = 1'b1;
            rd_val = 32'(inhibit) << 3;
        end
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (csr_addr == 12'hB03 + 12'(i)) begin
                rd_hit   = 1'b1;
                wr_ok    = 1'b1;
                we_lo[i] = 1'b1;
                rd_val   = cnt_lo[i];
            end
            if (csr_addr == 12'hB83 + 12'(i)) begin
                rd_hit   = 1'b1;
                wr_ok    = 1'b1;
                we_hi[i] = 1'b1;
                rd_val   = cnt_hi[i];
            end
            if (csr_addr == 12'hC03 + 12'(i)) begin
                rd_hit = 1'b1;
                rd_val = cnt_lo[i];
            end
            if (csr_addr == 12'hC83 + 12'(i)) begin
                rd_hit = 1'b1;
                rd_val = cnt_hi[i];
            end
            if (csr_addr == 12'h323 + 12'(i)) begin
                rd_hit   = 1'b1;
                wr_ok    = 1'b1;
                we_ev[i] = 1'b1;
                rd_val   = {ovf[i], 23'd0, evsel[i]};
            end
        end
    end

    assign accept = (state == IDLE) && csr_active;
    assign bad    = !rd_hit || (csr_write && !wr_ok);
    assign commit = accept && csr_write && !bad;

    always_comb begin
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            sel_ev[i] = pick_event(evsel[i], events);
            {lo_carry[i], lo_next[i]} = {1'b0, cnt_lo[i]} + 33'(inc_q[i]);
`ifdef HPM_OVF_EN
            {hi_wrap[i], hi_next[i]} = {1'b0, cnt_hi[i]} + 33'(carry_q[i]);
`else
            hi_next[i] = cnt_hi[i] + 32'(carry_q[i]);
`endif
        end
    end

    // CSR handshake: one ack per request, even if csr_active stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rdata_q <= '0;
            inv_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (csr_active) begin
                    state   <= RESP;
                    rdata_q <= bad ? 32'd0 : rd_val;
                    inv_q   <= bad;
                end
                RESP: state <= HOLD;
                HOLD: if (!csr_active) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign csr_ack     = (state == RESP);
    assign csr_rdata   = csr_ack ? rdata_q : 32'd0;
    assign csr_invalid = csr_ack & inv_q;

    // S1 selects the event, S2 adds into low, S3 ripples the carry into high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_q   <= '0;
            carry_q <= '0;
            inhibit <= '0;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_lo[i] <= '0;
                cnt_hi[i] <= '0;
                evsel[i]  <= '0;
            end
        end else begin
            inc_q <= sel_ev & ~inhibit;
            if (commit && we_inh) inhibit <= csr_wdata[3 +: NUM_COUNTERS];
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                if (commit && we_lo[i]) begin
                    cnt_lo[i]  <= csr_wdata;
                    carry_q[i] <= 1'b0;
                end else begin
                    cnt_lo[i]  <= lo_next[i];
                    carry_q[i] <= lo_carry[i];
                end
                if (commit && we_hi[i]) cnt_hi[i] <= csr_wdata;
                else                    cnt_hi[i] <= hi_next[i];
                if (commit && we_ev[i]) evsel[i] <= csr_wdata[7:0];
            end
        end
    end

`ifdef HPM_OVF_EN
    // A wrap of high beats a same-edge software clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= '0;
        end else begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                if (hi_wrap[i] && !(commit && we_hi[i])) ovf[i] <= 1'b1;
                else if (commit && we_ev[i])             ovf[i] <= csr_wdata[31];
            end
        end
    end
`else
    assign ovf = '0;
`endif

    assign overflow = ovf;

endmodule

// File: doc/hpm_counter_ctrl.md
# hpm_counter_ctrl

Controller and sequencer for the hardware performance-monitor counter bank in the privileged unit. It owns NUM_COUNTERS 64-bit event counters (mhpmcounter3+), their event-select and inhibit registers, and the 32-bit CSR access path that the privilege extension interface drives. Increments are pipelined so that a 64-bit add never sits in one cycle. It arbitrates CSR writes against in-flight increments and raises per-counter overflow.

## Interface
Parameters:
- NUM_COUNTERS, 2, number of counters, legal 1..29; counter i maps to mhpmcounter(3+i)
- NUM_EVENTS, 8, width of the event vector, legal 1..255

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- csr_active  in  1  CSR access request, level; held until ack seen
- csr_write  in  1  1 = write, 0 = read; valid with csr_active
- csr_addr  in  12  CSR address
- csr_wdata  in  32  write data
- csr_rdata  out  32  read data, valid while csr_ack=1
- csr_ack  out  1  one-cycle completion pulse
- csr_invalid  out  1  address not owned, or write to a read-only shadow; valid with csr_ack
- events  in  NUM_EVENTS  per-cycle event strobes from the core
- overflow  out  NUM_COUNTERS  sticky overflow flags (see Configuration)

## Operation
- Address map for counter i: mhpmcounter 0xB03+i (low 32 bits), mhpmcounterh 0xB83+i (high), hpmcounter 0xC03+i and 0xC83+i (read-only shadows), mhpmevent 0x323+i, mcountinhibit 0x320 (bit 3+i is the inhibit for counter i; other bits read 0 and ignore writes).
- mhpmevent[7:0] is the event field. Value e in 1..NUM_EVENTS selects events[e-1]. Value 0, or any value above NUM_EVENTS, never counts. Bits [30:8] read 0.
- Increment pipeline, per counter:
  - S1: inc_q[i] <= selected event & ~inhibit[i].
  - S2: low <= low + inc_q; carry_q[i] <= carry out of low.
  - S3: high <= high + carry_q.
- CSR FSM, states IDLE, RESP, HOLD:
  - IDLE→RESP when csr_active=1. The access is decoded and a write is committed on this edge.
  - RESP: csr_ack=1 with rdata/invalid valid; always moves to HOLD.
  - HOLD→IDLE when csr_active=0. A request still held high is not re-serviced.
- Write/increment collision, on the same edge:
  - Write to low wins over the S2 add and clears carry_q[i].
  - Write to high wins over the S3 carry add; the pending carry is dropped.
  - Write to mhpmevent or inhibit affects S1 from the next cycle. An inc_q already captured still completes.
- Reads return the register values as of the IDLE→RESP edge. A low/high pair is not atomic across two accesses.
- Invalid access: csr_ack=1, csr_invalid=1, csr_rdata=0, no state change.

## Timing
- Reset values: all counters 0, mhpmevent 0, inhibit 0, inc_q/carry_q 0, FSM IDLE, csr_ack 0, csr_invalid 0, csr_rdata 0, overflow 0.
- CSR latency: csr_ack asserts exactly 1 cycle after csr_active rises. Minimum spacing between accesses is 3 cycles.
- Event at cycle N: low updates at edge N+2. A carry into high lands at edge N+3.
- Wrap: low 0xFFFFFFFF+1 → 0 with carry; high wraps 0xFFFFFFFF→0 on carry.
- Reset mid-access: FSM returns to IDLE, csr_ack drops immediately, and the pipeline is flushed.

## Configuration
- HPM_OVF_EN defined:
  - A carry out of high bit 31 sets overflow[i].
  - overflow[i] reads as mhpmevent bit 31.
  - Writing mhpmevent bit 31 = 0 clears overflow[i]; writing 1 sets it.
  - If a clear and a wrap occur on the same edge, the wrap wins.
- HPM_OVF_EN undefined: overflow is tied to 0, mhpmevent bit 31 reads 0, and writes to it are ignored.

## Test plan
- Reset, then read 0xB03, 0x323 and 0x320 → each acks 1 cycle after request with rdata 0 and invalid 0.
- Write 0x323=1, pulse events[0] for 5 cycles → 0xB03 reads 5, with low updating 2 cycles after each strobe. Set 0x320 bit 3 → further strobes leave the count at 5.
- Write 0xB03=0xFFFFFFFE and 0x323=1, hold events[0] high → low goes ...FF then 0x0; 0xB83 reads 1 one cycle after low wraps.
- Same-edge write of 0x12345678 to 0xB03 while inc_q=1 → low reads 0x12345678 and high is unchanged.
- Write to 0xC03 or read 0x7C0 → ack=1, invalid=1, rdata=0, no register changes. Holding csr_active high produces only one ack.
- With HPM_OVF_EN: high=low=0xFFFFFFFF plus one event → overflow[0]=1 and 0x323 bit 31 reads 1. Writing 0x00000001 to 0x323 clears it.
